// File: rtl/nor_test_pkg.sv
// Shared types and constants for the 3-input NOR gate test sequencer.
package nor_test_pkg;

    localparam int VEC_COUNT = 8;
    localparam int ERR_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/nor_test_sequencer_hold_timer.sv
// Per-vector hold counter with synchronous clear and terminal-count flag.
module hold_timer #(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [7:0] TC_VAL = 8'(HOLD_CYCLES - 1);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/nor_test_sequencer.sv
// Walks all eight input vectors through a 3-input NOR gate and counts
// vectors whose output disagrees with the ideal NOR response.
module nor_test_sequencer
    import nor_test_pkg::*;
#(
    parameter int HOLD_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             dout_in,
    output logic             din_a,
    output logic             din_b,
    output logic             din_c,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_cnt,
    output logic             pass
);

    state_t     state;
    state_t     state_next;
    logic [2:0] vec_idx;
    logic [2:0] din;
    logic       tc;
    logic       last_vec;
    logic       launch;
    logic       step;
    logic       finish;
    logic       quit;
    logic       mismatch;

    assign last_vec = (vec_idx == 3'(VEC_COUNT - 1));
    assign mismatch = (dout_in != ~(|din));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        quit       = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start && !abort) begin
                    launch     = 1'b1;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (abort) begin
                    quit       = 1'b1;
                    state_next = IDLE;
                end else if (tc) begin
                    if (last_vec) begin
                        finish     = 1'b1;
                        state_next = DONE;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (launch | step | finish | quit),
        .enable(state == DRIVE),
        .tc    (tc)
    );

    // Gate output is judged only on the last hold cycle of each vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_idx <= '0;
            din     <= '0;
            err_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (launch) begin
            vec_idx <= '0;
            din     <= '0;
            err_cnt <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else if (quit) begin
            din  <= '0;
            busy <= 1'b0;
        end else if (step || finish) begin
            if (mismatch) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
            if (step) begin
                vec_idx <= vec_idx + 3'd1;
                din     <= vec_idx + 3'd1;
            end else begin
                din  <= '0;
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    assign din_a = din[2];
    assign din_b = din[1];
    assign din_c = din[0];
    assign pass  = done && (err_cnt == '0);

endmodule

// File: tb/tb_nor_test_sequencer.sv
// Scoreboard bench: runs queue expected results, a monitor checks each done.
module tb_nor_test_sequencer;

    typedef struct {
        int err;
        int pass;
        int start_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       dout_in;
    logic       din_a;
    logic       din_b;
    logic       din_c;
    logic       busy;
    logic       done;
    logic [3:0] err_cnt;
    logic       pass;

    int   mode = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    // 0: healthy NOR, 1: stuck-at-0, 2: stuck-at-1
    assign dout_in = (mode == 0) ? ~(din_a | din_b | din_c) : (mode == 2);

    nor_test_sequencer #(
        .HOLD_CYCLES(10)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .dout_in(dout_in),
        .din_a  (din_a),
        .din_b  (din_b),
        .din_c  (din_c),
        .busy   (busy),
        .done   (done),
        .err_cnt(err_cnt),
        .pass   (pass)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin : monitor
        logic done_q;
        exp_t e;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !done_q) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("err_cnt", int'(err_cnt), e.err);
                    check("pass", int'(pass), e.pass);
                    check("latency", cyc - e.start_cyc, 80);
                end
            end
            done_q = done;
        end
    end

    task automatic start_run(output int s);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n = n + 1;
        end
        if (!done) check("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    function automatic exp_t mk(input int err, input int p, input int s);
        exp_t e;
        e.err = err;
        e.pass = p;
        e.start_cyc = s;
        return e;
    endfunction

    initial begin
        int s;
        #12;
        check("rst_outputs", int'({din_a, din_b, din_c, busy, done, pass}), 0);
        check("rst_err", int'(err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // abort alone in IDLE, then start+abort together
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        check("idle_abort_busy", int'(busy), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", int'(busy), 0);

        // healthy gate, with a stray start pulse during vector 2
        mode = 0;
        start_run(s);
        sb.push_back(mk(0, 1, s));
        check("run_busy", int'(busy), 1);
        for (int k = 0; k < 8; k++) begin
            wait_until(s + 10 * k + 5);
            check($sformatf("vec%0d", k), int'({din_a, din_b, din_c}), k);
            if (k == 2) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        wait_done();
        check("done_din", int'({din_a, din_b, din_c, busy}), 0);

        mode = 1;
        start_run(s);
        sb.push_back(mk(1, 0, s));
        wait_done();

        mode = 2;
        start_run(s);
        sb.push_back(mk(7, 0, s));
        wait_done();
        check("done_hold", int'(done), 1);

        // restart from errored DONE, then abort during vector 3
        start_run(s);
        check("restart_err", int'(err_cnt), 0);
        check("restart_busy", int'(busy), 1);
        wait_until(s + 34);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_out", int'({din_a, din_b, din_c, busy, done}), 0);
        check("abort_err", int'(err_cnt), 2);

        mode = 0;
        start_run(s);
        sb.push_back(mk(0, 1, s));
        wait_done();

        // asynchronous reset during vector 5
        mode = 2;
        start_run(s);
        wait_until(s + 55);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", int'({din_a, din_b, din_c, busy, done, pass}), 0);
        check("async_rst_err", int'(err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_until(cyc + 100);
        check("post_rst_idle", int'({busy, done}), 0);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nor_test_sequencer.md
NOR_TEST_SEQUENCER -- requirements
Module: nor_test_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 10, sets the clock cycles each input vector is held; legal range 2..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a test run; sampled on rising edge.
REQ-005 abort  input  1  synchronous abort of a run in progress.
REQ-006 dout_in  input  1  output of the 3-input NOR gate under test.
REQ-007 din_a  output  1  gate input A, MSB of vector index.
REQ-008 din_b  output  1  gate input B, middle bit of vector index.
REQ-009 din_c  output  1  gate input C, LSB of vector index.
REQ-010 busy  output  1  high while vectors are being driven.
REQ-011 done  output  1  high after a completed run until the next start.
REQ-012 err_cnt  output  4  count of mismatching vectors in the last run, 0..8.
REQ-013 pass  output  1  high when done=1 and err_cnt=0.

Function
REQ-014 The FSM SHALL have three states:
- IDLE
- DRIVE
- DONE
REQ-015 In IDLE or DONE, start=1 and abort=0 SHALL enter DRIVE with the following updates:
- vec_idx=0, hold_cnt=0
- err_cnt cleared
- done=0, busy=1
REQ-016 In DRIVE, {din_a,din_b,din_c} SHALL equal vec_idx, registered; in IDLE and DONE they SHALL be 000.
REQ-017 In DRIVE, hold_cnt SHALL increment once per cycle, from 0 to HOLD_CYCLES-1.
REQ-018 On the edge where hold_cnt=HOLD_CYCLES-1:
- dout_in SHALL be compared against ~(din_a|din_b|din_c).
- On mismatch, err_cnt SHALL increment by 1.
REQ-019 On that same edge, if vec_idx<7: vec_idx SHALL increment and hold_cnt SHALL go to 0.
REQ-020 On that same edge, if vec_idx=7: the FSM SHALL enter DONE, with busy=0 and done=1.
REQ-021 Latency: done SHALL rise exactly 8*HOLD_CYCLES rising edges after the edge that sampled start (80 for the default).
REQ-022 start asserted while in DRIVE SHALL be ignored.
REQ-023 abort=1 in DRIVE SHALL return to IDLE on the next edge:
- outputs 000, busy=0, done=0
- err_cnt holds its partial value
REQ-024 abort=1 in IDLE or DONE SHALL have no effect.
REQ-025 If start and abort are both high, abort SHALL win and no run SHALL begin.
REQ-026 err_cnt SHALL never exceed 8; no wrap is possible.
REQ-027 pass SHALL be combinational from done and err_cnt.
REQ-028 In DONE, all outputs SHALL hold until the next start.

Reset
REQ-029 rst_n=0 SHALL immediately force all of the following, independent of clk:
- state=IDLE
- din_a=din_b=din_c=0
- busy=0, done=0, pass=0
- err_cnt=0, vec_idx=0, hold_cnt=0
REQ-030 rst_n asserted mid-run SHALL discard the run; after release the block SHALL wait in IDLE for start.
REQ-031 Reset release SHALL take effect on the first rising edge of clk after rst_n rises.

Structure
REQ-032 Shared package nor_test_pkg SHALL hold the following:
- FSM state encoding: IDLE=2'd0, DRIVE=2'd1, DONE=2'd2
- VEC_COUNT=8
- ERR_W=4
REQ-033 The hold counter SHALL be a sub-module hold_timer. It SHALL have:
- 8-bit count, clear input, enable input
- terminal-count output at HOLD_CYCLES-1
REQ-034 All other logic SHALL reside in nor_test_sequencer; target 150-250 lines of RTL.

Verification
REQ-035 Correct gate, default parameter:
- Stimulus: a working NOR gate drives dout_in; one-cycle start pulse.
- Required response: vectors 000..111 each held 10 cycles; done after 80 edges; err_cnt=0; pass=1.
REQ-036 Stuck-at-0 output:
- Stimulus: dout_in tied 0; start.
- Required response: only vector 000 mismatches; err_cnt=1; pass=0.
REQ-037 Stuck-at-1 output:
- Stimulus: dout_in tied 1; start.
- Required response: err_cnt=7; pass=0.
REQ-038 Abort mid-run:
- Stimulus: start, then abort during vector 3 (cycle 35).
- Required response: next edge gives IDLE, outputs 000, busy=0, done=0.
- A following start SHALL run the full sequence.
REQ-039 Asynchronous reset mid-run:
- Stimulus: rst_n pulsed low between clock edges during vector 5.
- Required response: all outputs 0 before the next edge; no done.
REQ-040 Restart behaviour:
- Stimulus: start re-pulsed during DRIVE.
- Required response: the pulse is ignored; timing is unchanged.
- Stimulus: start in DONE after an errored run.
- Required response: err_cnt clears to 0 and a new run begins.
